axis_tlast_framer: RTL and testbench

//   AXI4-Stream packet framer: accepts an unframed data stream and inserts TLAST on the beat that

---
 rtl/axis_tlast_framer_pkg.sv | 18 +
 rtl/axis_tlast_framer_if.sv | 12 +
 rtl/axis_tlast_framer_skid.sv | 59 +++++
 rtl/axis_tlast_framer.sv | 107 ++++++++++
 tb/tb_axis_tlast_framer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_tlast_framer_pkg.sv
// Shared types and width helpers for the AXIS TLAST framer and its output slice.
// A beat travels through the datapath packed as {tlast, tdata}.
package axis_tlast_framer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_e;

  function automatic int cnt_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  function automatic int beat_width(input int tdata_w);
    return tdata_w + 1;
  endfunction

endpackage

// File: rtl/axis_tlast_framer_if.sv
// AXI4-Stream handshake bundle shared by the framer ports and the bench.
interface axis_tlast_framer_if #(
  parameter int W = 32
);
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic [W-1:0] tdata;

  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_tlast_framer_skid.sv
// Generic two-slot AXIS register slice: a main output slot plus one skid slot.
// Ready is registered so the upstream never sees a combinational path from m_ready.
module axis_skid_buffer #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         main_valid;
  logic         skid_valid;
  logic         ready_q;
  logic         s_fire;
  logic         main_free;
  logic         skid_next;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;

  assign s_fire    = s_valid & ready_q;
  assign main_free = ~main_valid | m_ready;
  assign skid_next = ~main_free & (skid_valid | s_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_q    <= 1'b0;
    end else begin
      if (main_free) begin
        // skid content is always older than anything arriving now
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= s_fire;
          if (s_fire) main_data <= s_data;
        end
      end else if (s_fire) begin
        skid_valid <= 1'b1;
        skid_data  <= s_data;
      end
      ready_q <= ~skid_next;
    end
  end

  assign s_ready = ready_q;
  assign m_valid = main_valid;
  assign m_data  = main_data;

endmodule

// File: rtl/axis_tlast_framer.sv
// AXIS packet framer: marks TLAST on the beat closing a programmable-length packet
// or on force_tlast, then passes beats through a skid slice for full backpressure.
//   state     | meaning
//   ST_IDLE   | between packets, o_cnt == 0, next accepted beat latches the length
//   ST_IN_PKT | inside a packet, o_cnt beats accepted, length held in len_q
module axis_tlast_framer
  import axis_tlast_framer_pkg::*;
#(
  parameter  int TDATA_WIDTH    = 32,
  parameter  int MAX_PKT_LENGTH = 32,
  localparam int CNT_W          = cnt_width(MAX_PKT_LENGTH)
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     pkt_length,
  input  logic                 force_tlast,
  axis_tlast_framer_if.slave   s_axis,
  axis_tlast_framer_if.master  m_axis,
  output logic [CNT_W-1:0]     o_cnt,
  output logic [31:0]          o_pkt_count,
  output logic                 o_len_err
);

  localparam int               BW      = beat_width(TDATA_WIDTH);
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PKT_LENGTH);

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] len_q, len_d, len_san, len_eff;
  logic             len_bad;
  logic             err_q, err_d;
  logic             beat_last;
  logic             accept;
  logic             s_ready;
  logic [31:0]      pkt_q;
  logic [BW-1:0]    out_beat;

  assign accept  = s_axis.tvalid & s_ready;
  assign len_bad = (pkt_length == '0) || (pkt_length > MAX_LEN);
  assign len_san = len_bad ? MAX_LEN : pkt_length;
  // the first beat of a packet is tested against the length being latched with it
  assign len_eff   = (state_q == ST_IDLE) ? len_san : len_q;
  assign cnt_inc   = cnt_q + 1'b1;
  assign beat_last = force_tlast || (cnt_inc == len_eff);

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= MAX_LEN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = 1'b0;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        len_d = len_san;
        err_d = len_bad;
      end
      if (beat_last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_IN_PKT;
        cnt_d   = cnt_inc;
      end
    end
  end

  axis_skid_buffer #(.W(BW)) u_skid (
    .clk     (aclk),
    .reset   (reset),
    .s_valid (s_axis.tvalid),
    .s_ready (s_ready),
    .s_data  ({beat_last, s_axis.tdata}),
    .m_valid (m_axis.tvalid),
    .m_ready (m_axis.tready),
    .m_data  (out_beat)
  );

  assign s_axis.tready = s_ready;
  assign m_axis.tlast  = out_beat[BW-1];
  assign m_axis.tdata  = out_beat[TDATA_WIDTH-1:0];

  always_ff @(posedge aclk) begin
    if (reset) begin
      pkt_q <= '0;
    end else if (m_axis.tvalid && m_axis.tready && m_axis.tlast) begin
      pkt_q <= pkt_q + 32'd1;
    end
  end

  assign o_cnt       = cnt_q;
  assign o_pkt_count = pkt_q;
  assign o_len_err   = err_q;

endmodule

// File: tb/tb_axis_tlast_framer.sv
// Randomised self-checking bench for axis_tlast_framer against a queue-based packet model.
module tb_axis_tlast_framer;
  localparam int W    = 32;
  localparam int MAXL = 32;
  localparam int CW   = 6;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] pkt_length = '0;
  logic          force_tlast = 1'b0;
  logic [CW-1:0] o_cnt;
  logic [31:0]   o_pkt_count;
  logic          o_len_err;

  axis_tlast_framer_if #(.W(W)) s_if ();
  axis_tlast_framer_if #(.W(W)) m_if ();

  axis_tlast_framer #(.TDATA_WIDTH(W), .MAX_PKT_LENGTH(MAXL)) dut (
    .aclk        (aclk),
    .reset       (reset),
    .pkt_length  (pkt_length),
    .force_tlast (force_tlast),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .o_cnt       (o_cnt),
    .o_pkt_count (o_pkt_count),
    .o_len_err   (o_len_err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // packet model: expected beats in order, position in packet, latched length
  logic [W-1:0] q_data[$];
  bit           q_last[$];
  int           pos = 0;
  int           plen = MAXL;
  int           exp_pc = 0;
  bit           exp_err = 0;

  bit           hs_in, hs_out, obs_l, exp_l, q_under, ready_indep;
  bit           hold_chk, hold_ok, held_v, held_l;
  logic [W-1:0] obs_d, exp_d, held_d;

  task automatic model_clear();
    q_data.delete();
    q_last.delete();
    pos = 0; plen = MAXL; exp_pc = 0; exp_err = 0; held_v = 0;
  endtask

  // one clock of stimulus; updates the model, leaves observations for the caller to judge
  task automatic step(input bit v, input logic [W-1:0] d, input bit ft,
                      input logic [CW-1:0] len, input bit rdy);
    bit rb, lst;
    s_if.tvalid = v; s_if.tdata = d; s_if.tlast = 1'b0;
    force_tlast = ft; pkt_length = len; m_if.tready = rdy;
    @(negedge aclk);
    rb = s_if.tready;
    m_if.tready = ~rdy;
    #1 ready_indep = (s_if.tready === rb);
    m_if.tready = rdy;
    #1;
    hold_chk = held_v;
    hold_ok  = (m_if.tvalid === 1'b1) && (m_if.tdata === held_d) && (m_if.tlast === held_l);
    hs_out  = (m_if.tvalid === 1'b1) && rdy;
    q_under = 0;
    if (hs_out) begin
      obs_d = m_if.tdata; obs_l = m_if.tlast;
      if (q_data.size() == 0) q_under = 1;
      else begin
        exp_d = q_data.pop_front();
        exp_l = q_last.pop_front();
        if (exp_l) exp_pc++;
      end
    end
    held_v = (m_if.tvalid === 1'b1) && !rdy;
    held_d = m_if.tdata; held_l = m_if.tlast;
    hs_in = v && (rb === 1'b1);
    exp_err = 0;
    if (hs_in) begin
      if (pos == 0) begin
        exp_err = (len == 0) || (len > MAXL);
        plen = exp_err ? MAXL : int'(len);
      end
      pos++;
      lst = ft || (pos == plen);
      if (lst) pos = 0;
      q_data.push_back(d);
      q_last.push_back(lst);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_if.tvalid = 0; s_if.tdata = '1; s_if.tlast = 0; m_if.tready = 0;
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", s_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== '0) begin
      errors++; $display("FAIL rst_m got v=%b l=%b d=%h exp 0/0/0", m_if.tvalid, m_if.tlast, m_if.tdata); end
    checks++; if (o_cnt !== '0 || o_pkt_count !== '0 || o_len_err !== 1'b0) begin
      errors++; $display("FAIL rst_cnt got cnt=%0d pc=%0d err=%b exp 0", o_cnt, o_pkt_count, o_len_err); end
    reset = 1'b0;
    @(posedge aclk);
    #1;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", s_if.tready); end
    model_clear();
  endtask

  task automatic test_continuous();
    int nl = 0; int pc0 = exp_pc;
    for (int i = 0; i < 27; i++) begin
      step(i < 24, W'(i), 0, 6'd8, 1);
      if (hs_out) begin
        checks++; if (q_under || obs_d !== exp_d || obs_l !== exp_l) begin errors++;
          $display("FAIL cont_beat got %h/%b exp %h/%b", obs_d, obs_l, exp_d, exp_l); end
        if (obs_l) begin
          nl++;
          checks++; if (obs_d % 8 != 7) begin errors++; $display("FAIL cont_tlast_pos got data %0d exp 7 mod 8", obs_d); end
        end
      end
      if (i >= 1 && i <= 24) begin
        checks++; if (!hs_out) begin errors++; $display("FAIL cont_bubble got tvalid 0 at cycle %0d exp 1", i); end
      end
      checks++; if (o_cnt !== CW'(pos)) begin errors++; $display("FAIL cont_cnt got %0d exp %0d", o_cnt, pos); end
    end
    checks++; if (nl != 3 || o_pkt_count !== 32'(pc0 + 3)) begin errors++;
      $display("FAIL cont_pkts got tlasts=%0d pc=%0d exp 3/%0d", nl, o_pkt_count, pc0 + 3); end
  endtask

  task automatic test_sparse();
    int nb = 0; int nl = 0;
    for (int i = 0; i < 48 * 6 + 3; i++) begin
      step((i % 6 == 0) && nb < 48, W'($urandom), 0, 6'd8, 1);
      if (hs_in) nb++;
      if (hs_out) begin
        if (obs_l) nl++;
        checks++; if (q_under || obs_d !== exp_d || obs_l !== exp_l) begin errors++;
          $display("FAIL sparse_beat got %h/%b exp %h/%b", obs_d, obs_l, exp_d, exp_l); end
      end
      checks++; if (o_cnt !== CW'(pos)) begin errors++; $display("FAIL sparse_cnt got %0d exp %0d", o_cnt, pos); end
    end
    checks++; if (nl != 6 || o_pkt_count !== 32'(exp_pc)) begin errors++;
      $display("FAIL sparse_pkts got tlasts=%0d pc=%0d exp 6/%0d", nl, o_pkt_count, exp_pc); end
  endtask

  task automatic test_force();
    int nl = 0; int nout = 0; int lpos[$];
    for (int i = 0; i < 15; i++) begin
      step(i < 12, W'($urandom), i == 3, 6'd8, 1);
      if (i == 3) begin
        checks++; if (o_cnt !== '0) begin errors++; $display("FAIL force_cnt got %0d exp 0", o_cnt); end
      end
      if (hs_out) begin
        if (obs_l) begin nl++; lpos.push_back(nout); end
        nout++;
        checks++; if (q_under || obs_d !== exp_d || obs_l !== exp_l) begin errors++;
          $display("FAIL force_beat got %h/%b exp %h/%b", obs_d, obs_l, exp_d, exp_l); end
      end
    end
    checks++; if (nl != 2 || lpos[0] != 3 || lpos[1] != 11) begin errors++;
      $display("FAIL force_frame got %0d tlasts first at %0d exp 2 at 3 and 11", nl, (nl > 0) ? lpos[0] : -1); end
  endtask

  task automatic test_len_err();
    int npulse = 0; int nl = 0;
    logic [CW-1:0] len;
    for (int i = 0; i < 70; i++) begin
      len = (i < 32) ? 6'd0 : (i < 64) ? 6'd40 : 6'd1;
      step(i < 67, W'($urandom), 0, len, 1);
      if (o_len_err === 1'b1) npulse++;
      checks++; if (o_len_err !== exp_err) begin errors++; $display("FAIL len_err got %b exp %b cycle %0d", o_len_err, exp_err, i); end
      checks++; if (o_cnt !== CW'(pos)) begin errors++; $display("FAIL len_cnt got %0d exp %0d", o_cnt, pos); end
      if (hs_out) begin
        if (obs_l) nl++;
        checks++; if (q_under || obs_d !== exp_d || obs_l !== exp_l) begin errors++;
          $display("FAIL len_beat got %h/%b exp %h/%b", obs_d, obs_l, exp_d, exp_l); end
      end
    end
    checks++; if (npulse != 2 || nl != 5) begin errors++;
      $display("FAIL len_summary got pulses=%0d tlasts=%0d exp 2/5", npulse, nl); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 340; i++) begin
      step(i < 300, W'($urandom), $urandom_range(0, 9) == 0, CW'($urandom_range(1, 12)),
           (i >= 300) || ($urandom_range(0, 1) == 1));
      checks++; if (!ready_indep) begin errors++; $display("FAIL bp_ready_comb got tready change with m_tready exp none"); end
      if (hold_chk) begin
        checks++; if (!hold_ok) begin errors++; $display("FAIL bp_hold got v=%b d=%h l=%b exp 1/%h/%b",
          m_if.tvalid, m_if.tdata, m_if.tlast, held_d, held_l); end
      end
      if (hs_out) begin
        checks++; if (q_under || obs_d !== exp_d || obs_l !== exp_l) begin errors++;
          $display("FAIL bp_beat got %h/%b exp %h/%b", obs_d, obs_l, exp_d, exp_l); end
      end
      checks++; if (o_cnt !== CW'(pos) || o_pkt_count !== 32'(exp_pc)) begin errors++;
        $display("FAIL bp_counts got cnt=%0d pc=%0d exp %0d/%0d", o_cnt, o_pkt_count, pos, exp_pc); end
    end
    checks++; if (q_data.size() != 0) begin errors++; $display("FAIL bp_drain got %0d beats left exp 0", q_data.size()); end
  endtask

  task automatic test_len_change_reset();
    int nout = 0; int lpos[$]; int nacc = 0;
    for (int i = 0; i < 14; i++) begin
      step(i < 12, W'($urandom), 0, (i < 5) ? 6'd8 : 6'd4, 1);
      if (hs_out) begin
        if (obs_l) lpos.push_back(nout);
        nout++;
        checks++; if (q_under || obs_d !== exp_d || obs_l !== exp_l) begin errors++;
          $display("FAIL chg_beat got %h/%b exp %h/%b", obs_d, obs_l, exp_d, exp_l); end
      end
    end
    checks++; if (lpos.size() != 2 || lpos[0] != 7 || lpos[1] != 11) begin errors++;
      $display("FAIL chg_frame got %0d tlasts first at %0d exp 2 at 7 and 11", lpos.size(), (lpos.size() > 0) ? lpos[0] : -1); end
    checks++; if (o_pkt_count !== 32'(exp_pc)) begin errors++; $display("FAIL chg_pc got %0d exp %0d", o_pkt_count, exp_pc); end
    while (nacc < 5) begin
      step(1, W'($urandom), 0, 6'd8, 1);
      if (hs_in) nacc++;
    end
    reset = 1'b1; s_if.tvalid = 1'b1;
    @(posedge aclk);
    #1 reset = 1'b0;
    model_clear();
    checks++; if (m_if.tvalid !== 1'b0 || o_cnt !== '0 || o_pkt_count !== '0) begin errors++;
      $display("FAIL chg_reset got v=%b cnt=%0d pc=%0d exp 0/0/0", m_if.tvalid, o_cnt, o_pkt_count); end
    lpos.delete(); nout = 0;
    for (int i = 0; i < 8; i++) begin
      step(i < 5, W'($urandom), 0, 6'd4, 1);
      if (hs_out) begin
        if (obs_l) lpos.push_back(nout);
        nout++;
        checks++; if (q_under || obs_d !== exp_d || obs_l !== exp_l) begin errors++;
          $display("FAIL post_rst_beat got %h/%b exp %h/%b", obs_d, obs_l, exp_d, exp_l); end
      end
    end
    checks++; if (nout != 4 || lpos.size() != 1 || o_pkt_count !== 32'd1) begin errors++;
      $display("FAIL post_rst_pkt got beats=%0d tlasts=%0d pc=%0d exp 4/1/1", nout, lpos.size(), o_pkt_count); end
  endtask

  initial begin
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tlast = 0; m_if.tready = 0;
    test_reset();
    test_continuous();
    test_sparse();
    test_force();
    test_len_err();
    test_backpressure();
    test_len_change_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
